// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and FSM state encodings for the TX and RX paths
package uart_pkg;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_OVS     = 16;
    localparam int DEF_SB_TICK = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock fall-through FIFO with occupancy and overflow pulse
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_ok;
    logic          rd_ok;

    // A write while full is dropped even when a pop frees a slot in the same cycle.
    assign wr_ok   = wr && !full;
    assign rd_ok   = rd && !empty;
    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr && full;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter, optional parity bit via UART_TX_PARITY_EN
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int OVS     = DEF_OVS,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tick,
    input  logic             wr_en,
    input  logic [DBIT-1:0]  wr_data,
    input  logic             parity_odd,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] level,
    output logic             overflow,
    output logic             tx_busy,
    output logic             tx_done_tick,
    output logic             tx
);

    localparam int CW = $clog2(OVS > SB_TICK ? OVS : SB_TICK);
    localparam int NW = $clog2(DBIT);

    logic [2:0]      state;
    logic [CW-1:0]   s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] shift;
    logic [DBIT-1:0] fifo_data;
    logic            tx_q;
    logic            bit_end;
    logic            frame_end;
    logic            pop;

    sync_fifo #(
        .DW (DBIT),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr_en),
        .wr_data  (wr_data),
        .rd       (pop),
        .rd_data  (fifo_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    assign bit_end   = s_tick && (s_cnt == CW'(OVS - 1));
    assign frame_end = (state == ST_STOP) && s_tick && (s_cnt == CW'(SB_TICK - 1));
    // Popping on the last stop tick chains frames with no idle gap.
    assign pop          = !empty && ((state == ST_IDLE) || frame_end);
    assign tx_done_tick = frame_end;
    assign tx_busy      = (state != ST_IDLE);
    assign tx           = tx_q;

`ifdef UART_TX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (pop) begin
            par_bit <= (^fifo_data) ^ parity_odd;
        end
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            s_cnt <= '0;
            n_cnt <= '0;
            shift <= '0;
            tx_q  <= 1'b1;
        end else if (pop) begin
            state <= ST_START;
            s_cnt <= '0;
            n_cnt <= '0;
            shift <= fifo_data;
            tx_q  <= 1'b0;
        end else if (s_tick) begin
            case (state)
                ST_START: begin
                    if (bit_end) begin
                        s_cnt <= '0;
                        state <= ST_DATA;
                        tx_q  <= shift[0];
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        s_cnt <= '0;
                        shift <= shift >> 1;
                        if (n_cnt == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx_q  <= par_bit;
`else
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            n_cnt <= n_cnt + 1'b1;
                            tx_q  <= shift[1];
                        end
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        s_cnt <= '0;
                        state <= ST_STOP;
                        tx_q  <= 1'b1;
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (frame_end) begin
                        s_cnt <= '0;
                        state <= ST_IDLE;
                    end else begin
                        s_cnt <= s_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    tx_q <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       s_tick     = 1'b0;
    logic       wr_en      = 1'b0;
    logic       wr_en2     = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] wr_data    = 8'h00;
    logic [4:0] wr_data2   = 5'h00;

    logic       full, empty, overflow, tx_busy, tx_done_tick, tx;
    logic [4:0] level;
    logic       full2, empty2, overflow2, busy2, done2, tx2;
    logic [2:0] level2;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .parity_odd   (parity_odd),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    uart_tx_fifo #(
        .DBIT    (5),
        .OVS     (16),
        .SB_TICK (32),
        .FIFO_AW (2)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .wr_en        (wr_en2),
        .wr_data      (wr_data2),
        .parity_odd   (parity_odd),
        .full         (full2),
        .empty        (empty2),
        .level        (level2),
        .overflow     (overflow2),
        .tx_busy      (busy2),
        .tx_done_tick (done2),
        .tx           (tx2)
    );

    always #5 clk = ~clk;

    // s_tick: one clk wide, every 4th clk, changed just after the rising edge
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            div    = (div + 1) % 4;
            s_tick = (div == 0);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int d);
        return (d == 0) ? tx : tx2;
    endfunction

    function automatic logic done_of(input int d);
        return (d == 0) ? tx_done_tick : done2;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? tx_busy : busy2;
    endfunction

    task automatic wait_ticks(input int n);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < n * 4 + 20) begin
            @(negedge clk);
            cyc++;
            if (s_tick) k++;
        end
        chk("tick_budget", k, n);
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!tx_done_tick && cyc < 2000);
        chk(tag, tx_done_tick, 1'b1);
    endtask

    // Entered just after the edge that loads START; samples each bit at its middle.
    task automatic check_frame(input int d, input logic [15:0] data, input int dbit,
                               input int sb, input string tag);
        logic p;
        p = (^data) ^ parity_odd;
        wait_ticks(8);
        chk($sformatf("%s_start", tag), tx_of(d), 1'b0);
        for (int i = 0; i < dbit; i++) begin
            wait_ticks(16);
            chk($sformatf("%s_d%0d", tag, i), tx_of(d), data[i]);
        end
`ifdef UART_TX_PARITY_EN
        wait_ticks(16);
        chk($sformatf("%s_par", tag), tx_of(d), p);
`else
        p = 1'b0;
`endif
        wait_ticks(16);
        chk($sformatf("%s_stop", tag), tx_of(d), 1'b1);
        chk($sformatf("%s_early_done", tag), done_of(d), 1'b0);
        wait_ticks(sb - 8);
        chk($sformatf("%s_done", tag), done_of(d), 1'b1);
        chk($sformatf("%s_busy_at_done", tag), busy_of(d), 1'b1);
    endtask

    task automatic frame_test(input int d, input logic [15:0] data, input int dbit,
                              input int sb, input string tag);
        @(posedge clk);
        #1;
        if (d == 0) begin
            wr_data = data[7:0];
            wr_en   = 1'b1;
        end else begin
            wr_data2 = data[4:0];
            wr_en2   = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        wr_en2 = 1'b0;
        chk($sformatf("%s_tx_pre", tag), tx_of(d), 1'b1);
        @(posedge clk);
        #1;
        chk($sformatf("%s_tx_fall", tag), tx_of(d), 1'b0);
        check_frame(d, data, dbit, sb, tag);
        @(negedge clk);
        chk($sformatf("%s_done_pulse", tag), done_of(d), 1'b0);
        chk($sformatf("%s_busy_end", tag), busy_of(d), 1'b0);
        chk($sformatf("%s_tx_idle", tag), tx_of(d), 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level, 5'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done_tick, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_tx2", tx2, 1'b1);
        reset = 1'b0;

        // single frame, 0xA5
        frame_test(0, 16'h00A5, 8, 16, "t1");

        // three back-to-back frames
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_data = 8'h01;
        @(posedge clk);
        #1;
        wr_data = 8'h02;
        @(posedge clk);
        #1;
        wr_data = 8'h03;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("t2_level", level, 5'd2);
        wait_done("t2_done1");
        check_frame(0, 16'h0002, 8, 16, "t2f2");
        check_frame(0, 16'h0003, 8, 16, "t2f3");
        @(negedge clk);
        chk("t2_busy_end", tx_busy, 1'b0);
        chk("t2_level_end", level, 5'd0);
        chk("t2_empty_end", empty, 1'b1);

        // fill to full, overflow, rejected push during pop
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'h10 + 8'(i);
            @(posedge clk);
            #1;
        end
        chk("t3_level_full", level, 5'd16);
        chk("t3_full", full, 1'b1);
        chk("t3_no_ovf", overflow, 1'b0);
        wr_data = 8'hEE;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_level_hold", level, 5'd16);
        @(posedge clk);
        #1;
        chk("t3_ovf_once", overflow, 1'b0);
        wait_done("t3_done0");
        chk("t3_full_at_pop", full, 1'b1);
        wr_en   = 1'b1;
        wr_data = 8'hDD;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("t3_ovf_pop", overflow, 1'b1);
        chk("t3_level_pop", level, 5'd15);
        for (int i = 1; i < 17; i++) begin
            check_frame(0, 16'h0010 + 16'(i), 8, 16, $sformatf("t3f%0d", i));
        end
        @(negedge clk);
        chk("t3_busy_end", tx_busy, 1'b0);
        chk("t3_empty_end", empty, 1'b1);

        // reset mid-frame
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        @(posedge clk);
        #1;
        wr_data = 8'h66;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        wait_ticks(69);
        chk("t4_tx_bit3", tx, 1'b0);
        chk("t4_level_pre", level, 5'd1);
        reset = 1'b1;
        #1;
        chk("t4_tx_rst", tx, 1'b1);
        chk("t4_level_rst", level, 5'd0);
        chk("t4_busy_rst", tx_busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        frame_test(0, 16'h003C, 8, 16, "t4");

        // parity polarity (parity bit checked only when enabled)
        parity_odd = 1'b0;
        frame_test(0, 16'h00A5, 8, 16, "t5a");
        frame_test(0, 16'h0007, 8, 16, "t5b");
        parity_odd = 1'b1;
        frame_test(0, 16'h00A5, 8, 16, "t5c");
        frame_test(0, 16'h0007, 8, 16, "t5d");
        parity_odd = 1'b0;

        // DBIT=5, two stop bits
        frame_test(1, 16'h001F, 5, 32, "t6");
        chk("t6_empty", empty2, 1'b1);
        chk("t6_tx1_idle", tx, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
